pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. Drives the hold and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from three hazard sources: data-cache miss, load-use dependency and taken branch. On a data-cache miss it runs the refill handshake with main memory and freezes the pipeline until the refill completes. It also keeps a saturating count of stall cycles for performance reporting.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width
- CNT_W, 16, stall-counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  pipeline clock
- rst_i  in  1  synchronous reset, active-high
- dcache_miss_i  in  1  MEM-stage access missed in data cache
- id_ex_memread_i  in  1  instruction in EX is a load
- id_ex_rt_i  in  REG_ADDR_W  load destination in EX
- if_id_rs_i  in  REG_ADDR_W  rs of instruction in ID
- if_id_rt_i  in  REG_ADDR_W  rt of instruction in ID
- branch_taken_i  in  1  branch in ID resolved taken
- mem_ack_i  in  1  main memory completed refill (1-cycle pulse)
- pc_en_o  out  1  PC update enable
- if_id_en_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID loads NOP
- id_ex_flush_o  out  1  ID/EX loads bubble (all control zero)
- ex_mem_en_o  out  1  EX/MEM load enable
- mem_wb_bubble_o  out  1  MEM/WB loads RegWrite=0, MemToReg=0
- mem_req_o  out  1  refill request to main memory (registered)
- cache_fill_o  out  1  write refill line into data cache
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, saturating

## Operation
- FSM states:
  - RUN: normal flow.
  - MISS_REQ: waiting for memory.
  - MISS_FILL: one-cycle cache write.
- Transitions:
  - RUN → MISS_REQ on dcache_miss_i.
  - MISS_REQ → MISS_FILL on mem_ack_i.
  - MISS_FILL → RUN unconditionally.
- Load-use hazard: id_ex_memread_i & (id_ex_rt_i ≠ 0) & (id_ex_rt_i == if_id_rs_i | id_ex_rt_i == if_id_rt_i).
- Priority in RUN: miss > load-use > branch.
  - Miss (RUN with dcache_miss_i, or any MISS_* state):
    - pc_en_o=0, if_id_en_o=0, ex_mem_en_o=0.
    - id_ex_flush_o=0, so ID/EX holds.
    - mem_wb_bubble_o=1, so WB never re-retires.
    - branch_taken_i and load-use are ignored.
  - Load-use only:
    - pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1.
    - ex_mem_en_o=1.
    - if_id_flush_o=0 even if branch_taken_i=1; the branch is re-evaluated next cycle.
  - Branch only: if_id_flush_o=1; all enables 1.
  - No hazard: all enables 1, all flushes/bubble 0.
- On return to RUN, the missed access is re-presented and now hits.
- mem_req_o is 1 exactly while in MISS_REQ. It stays high until mem_ack_i, and drops the cycle after the ack.
- cache_fill_o is 1 exactly while in MISS_FILL.
- mem_ack_i outside MISS_REQ is ignored.
- stall_cnt_o increments every cycle pc_en_o=0 and holds at 2^CNT_W−1.

## Timing
- Enables, flushes and bubble are combinational (Mealy) from the registered state and current inputs, so the pipeline registers act on them in the same edge.
- mem_req_o and cache_fill_o are decoded from the state register only.
- Miss penalty is N+2 frozen cycles for an ack N cycles after req rises (N≥1): the RUN detect cycle, N MISS_REQ cycles and 1 MISS_FILL cycle.
- Load-use costs exactly one bubble.
- Reset values (state RUN): mem_req_o=0, cache_fill_o=0, stall_cnt_o=0, pc_en_o=1, if_id_en_o=1, ex_mem_en_o=1, flushes/bubble 0 with no hazard inputs.
- Reset mid-miss: the next cycle is RUN with mem_req_o=0. A late mem_ack_i is ignored.
- Simultaneous mem_ack_i and rst_i: reset wins.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum (RUN, MISS_REQ, MISS_FILL);
  - REG_ADDR_W and CNT_W defaults;
  - the NOP encoding constant.
- Sub-module hazard_detect: purely combinational load-use compare, outputs a single load_use flag.
- The FSM, the output decode and the counter live in pipeline_ctrl.

## Test plan
- Idle: no hazard inputs for 10 cycles → all enables 1, flushes 0, stall_cnt_o=0.
- Load-use: id_ex_memread_i=1, id_ex_rt_i=8, if_id_rs_i=8 → one cycle of pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; stall_cnt_o=1.
- Load-use with rt=0: id_ex_rt_i=0, if_id_rs_i=0 → no stall.
- Miss with ack 3 cycles after req:
  - 5 frozen cycles, mem_wb_bubble_o=1 throughout.
  - mem_req_o high 3 cycles.
  - cache_fill_o high 1 cycle.
  - stall_cnt_o=5.
- Miss, load-use and branch in the same cycle → miss controls apply, if_id_flush_o=0. After the refill, load-use fires first, then the branch flush.
- Reset during MISS_REQ, then mem_ack_i → state RUN, mem_req_o=0, cache_fill_o never asserted, stall_cnt_o=0. Preloaded near saturation, stall_cnt_o sticks at 65535.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Default widths for the register address and the stall counter.
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF      = 16;

    // Instruction word loaded into IF/ID on a flush (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequencer states: normal flow, waiting on memory, one-cycle line write.
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMissReq  = 2'd1,
        StMissFill = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register read by the instruction in ID.
module hazard_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    output logic                  load_use
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = id_ex_memread && (id_ex_rt != '0) &&
                   ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: hazard priority decode, cache refill FSM, stall counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dcache_miss_i,
    input  logic                  id_ex_memread_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_ack_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_en_o,
    output logic                  mem_wb_bubble_o,
    output logic                  mem_req_o,
    output logic                  cache_fill_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             freeze;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_ex_memread (id_ex_memread_i),
        .id_ex_rt      (id_ex_rt_i),
        .if_id_rs      (if_id_rs_i),
        .if_id_rt      (if_id_rt_i),
        .load_use      (load_use)
    );

    // State register; reset wins over a coincident mem_ack_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Refill sequencing; acks outside StMissReq fall through the default hold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:      if (dcache_miss_i) state_d = StMissReq;
            StMissReq:  if (mem_ack_i)     state_d = StMissFill;
            StMissFill: state_d = StRun;
            default:    state_d = StRun;
        endcase
    end

    // Pipeline controls: miss freezes everything, else load-use bubbles, else branch flushes.
    always_comb begin
        pc_en_o         = 1'b1;
        if_id_en_o      = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_en_o     = 1'b1;
        mem_wb_bubble_o = 1'b0;
        freeze          = (state_q != StRun) || dcache_miss_i;
        if (freeze) begin
            // ID/EX holds (no flush) so the frozen instruction survives the refill.
            pc_en_o         = 1'b0;
            if_id_en_o      = 1'b0;
            ex_mem_en_o     = 1'b0;
            mem_wb_bubble_o = 1'b1;
        end else if (load_use) begin
            // Branch flush is suppressed; the branch re-resolves once the bubble passes.
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    // Memory handshake outputs depend on the state register only.
    always_comb begin
        mem_req_o    = (state_q == StMissReq);
        cache_fill_o = (state_q == StMissFill);
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes model expectations, a monitor compares.
module tb_pipeline_ctrl;

    localparam int RW = 5;
    localparam int CW = 16;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic          clk_i;
    logic          rst_i;
    logic          dcache_miss_i;
    logic          id_ex_memread_i;
    logic [RW-1:0] id_ex_rt_i;
    logic [RW-1:0] if_id_rs_i;
    logic [RW-1:0] if_id_rt_i;
    logic          branch_taken_i;
    logic          mem_ack_i;
    logic          pc_en_o;
    logic          if_id_en_o;
    logic          if_id_flush_o;
    logic          id_ex_flush_o;
    logic          ex_mem_en_o;
    logic          mem_wb_bubble_o;
    logic          mem_req_o;
    logic          cache_fill_o;
    logic [CW-1:0] stall_cnt_o;

    pipeline_ctrl #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dcache_miss_i   (dcache_miss_i),
        .id_ex_memread_i (id_ex_memread_i),
        .id_ex_rt_i      (id_ex_rt_i),
        .if_id_rs_i      (if_id_rs_i),
        .if_id_rt_i      (if_id_rt_i),
        .branch_taken_i  (branch_taken_i),
        .mem_ack_i       (mem_ack_i),
        .pc_en_o         (pc_en_o),
        .if_id_en_o      (if_id_en_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .ex_mem_en_o     (ex_mem_en_o),
        .mem_wb_bubble_o (mem_wb_bubble_o),
        .mem_req_o       (mem_req_o),
        .cache_fill_o    (cache_fill_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          pc_en;
        logic          if_id_en;
        logic          if_id_flush;
        logic          id_ex_flush;
        logic          ex_mem_en;
        logic          bubble;
        logic          req;
        logic          fill;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model: where the refill transaction stands, and stall cycles so far.
    int          refill_phase = 0;  // 0 none, 1 awaiting memory, 2 writing line
    int unsigned m_cnt        = 0;
    bit          model_ok     = 1'b0;
    string       cur_tag      = "init";

    // One clock: drive inputs, queue expected outputs, advance the model past the edge.
    task automatic cycle(input bit rst, input bit miss, input bit mr, input bit [RW-1:0] ex_rt,
                         input bit [RW-1:0] rs, input bit [RW-1:0] rt, input bit br,
                         input bit ack);
        exp_t e;
        bit   frozen;
        bit   lu;
        bit   stall;
        rst_i           = rst;
        dcache_miss_i   = miss;
        id_ex_memread_i = mr;
        id_ex_rt_i      = ex_rt;
        if_id_rs_i      = rs;
        if_id_rt_i      = rt;
        branch_taken_i  = br;
        mem_ack_i       = ack;
        lu     = mr && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
        frozen = (refill_phase != 0) || miss;
        stall  = frozen || lu;
        e.pc_en       = !stall;
        e.if_id_en    = !stall;
        e.ex_mem_en   = !frozen;
        e.id_ex_flush = !frozen && lu;
        e.if_id_flush = !stall && br;
        e.bubble      = frozen;
        e.req         = (refill_phase == 1);
        e.fill        = (refill_phase == 2);
        e.cnt         = m_cnt[CW-1:0];
        if (model_ok) begin
            sb.push_back(e);
            tag_q.push_back(cur_tag);
        end
        @(posedge clk_i);
        #1;
        if (rst) begin
            refill_phase = 0;
            m_cnt        = 0;
            model_ok     = 1'b1;
        end else if (model_ok) begin
            if (stall && m_cnt < MAXC) m_cnt++;
            if (refill_phase == 0 && miss)     refill_phase = 1;
            else if (refill_phase == 1 && ack) refill_phase = 2;
            else if (refill_phase == 2)        refill_phase = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Directed check on a registered output, called right after a cycle() returns.
    task automatic expect_eq(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a full control vector; compare mid-cycle.
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string t;
            e = sb.pop_front();
            t = tag_q.pop_front();
            g = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_en_o,
                 mem_wb_bubble_o, mem_req_o, cache_fill_o, stall_cnt_o};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got pc=%b ifid_en=%b ifid_fl=%b idex_fl=%b exmem=%b bub=%b req=%b fill=%b cnt=%0d, expected pc=%b ifid_en=%b ifid_fl=%b idex_fl=%b exmem=%b bub=%b req=%b fill=%b cnt=%0d",
                         t, $time, g.pc_en, g.if_id_en, g.if_id_flush, g.id_ex_flush,
                         g.ex_mem_en, g.bubble, g.req, g.fill, g.cnt, e.pc_en, e.if_id_en,
                         e.if_id_flush, e.id_ex_flush, e.ex_mem_en, e.bubble, e.req, e.fill,
                         e.cnt);
            end
        end
    end

    initial begin
        int base;
        int fill_seen;

        cur_tag = "reset";
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        expect_eq("reset_cnt", stall_cnt_o, 0);
        expect_eq("reset_req", mem_req_o, 0);

        cur_tag = "idle";
        idle(10);
        expect_eq("idle_cnt", stall_cnt_o, 0);

        cur_tag = "load_use";
        cycle(0, 0, 1, 8, 8, 3, 0, 0);
        expect_eq("load_use_cnt", stall_cnt_o, 1);
        idle(1);

        cur_tag = "load_use_r0";
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        expect_eq("load_use_r0_cnt", stall_cnt_o, 1);

        cur_tag = "miss_n3";
        base = stall_cnt_o;
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        expect_eq("miss_req_rise", mem_req_o, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        expect_eq("miss_req_drop", mem_req_o, 0);
        expect_eq("miss_fill", cache_fill_o, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        expect_eq("miss_fill_end", cache_fill_o, 0);
        expect_eq("miss_penalty", stall_cnt_o - base, 5);
        idle(2);

        cur_tag = "miss_lu_branch";
        cycle(0, 1, 1, 4, 2, 4, 1, 0);
        cycle(0, 0, 1, 4, 2, 4, 1, 1);
        cycle(0, 0, 1, 4, 2, 4, 1, 0);
        cycle(0, 0, 1, 4, 2, 4, 1, 0);
        cycle(0, 0, 0, 4, 2, 4, 1, 0);
        idle(2);

        cur_tag = "reset_mid_miss";
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        expect_eq("mid_miss_req", mem_req_o, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        expect_eq("rst_ack_req", mem_req_o, 0);
        expect_eq("rst_ack_cnt", stall_cnt_o, 0);
        fill_seen = cache_fill_o;
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        fill_seen |= cache_fill_o;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        fill_seen |= cache_fill_o;
        expect_eq("late_ack_no_fill", fill_seen, 0);
        expect_eq("late_ack_cnt", stall_cnt_o, 0);

        cur_tag = "random";
        for (int i = 0; i < 400; i++) begin
            cycle(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                  RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        cur_tag = "saturate";
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        expect_eq("sat_hold", stall_cnt_o, 65535);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 7, 7, 0, 0, 0);
        expect_eq("sat_sticky", stall_cnt_o, 65535);
        idle(2);

        @(negedge clk_i);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
